toy_phy_freelist_ckpt: RTL and testbench
========================================

Name: toy_phy_freelist_ckpt

Overview:
Parametrised physical-register free list for the rename stage, serving INT or FLOAT register files through MODE. It hands out up to DECODE_NUM physical IDs per cycle and accepts up to COMMIT_NUM released IDs per cycle. It keeps a committed allocation pointer for full pipeline cancel. It adds CKPT_NUM branch checkpoints of the allocation pointer, so a mispredict can restore without a full flush.

Parameters:
MODE, 0, 0 = INT, 1 = FLOAT; no behavioural difference, carried for instance identification.
PHY_NUM, 64, number of physical registers; must be a power of 2.
ARCH_NUM, 32, architectural registers; physical IDs 0..ARCH_NUM-1 are mapped at reset.
DECODE_NUM, 4, allocation lanes.
COMMIT_NUM, 4, commit/release channels.
CKPT_NUM, 4, checkpoint slots; must be a power of 2.
ID_W, $clog2(PHY_NUM), physical ID width (derived).
CK_W, $clog2(CKPT_NUM), checkpoint tag width (derived).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
v_alloc_vld  out  DECODE_NUM  lane i may allocate: free_cnt > i
v_alloc_rdy  in  DECODE_NUM  lane i consumes this cycle; must be a prefix (contiguous from lane 0)
v_alloc_zero  in  DECODE_NUM  lane's rd is x0; no ID consumed
v_alloc_id  out  ID_W x DECODE_NUM  ID offered to lane i
v_commit_en  in  COMMIT_NUM  instruction retires
v_commit_alloc  in  COMMIT_NUM  retiring instruction had allocated an ID
v_release_en  in  COMMIT_NUM  return old physical ID to the list
v_release_id  in  ID_W x COMMIT_NUM  ID being returned
cancel_edge_en  in  1  full flush to committed state
ckpt_en  in  1  take checkpoint this cycle
ckpt_tag  in  CK_W  slot to write
restore_en  in  1  branch mispredict restore
restore_tag  in  CK_W  slot to restore
ckpt_free_en  in  1  invalidate slot (branch resolved correct)
ckpt_free_tag  in  CK_W  slot to invalidate
free_cnt  out  ID_W+1  current free entries (registered)
ckpt_err  out  1  one-cycle pulse: restore requested on an invalid slot

Behaviour:
- Storage: circular queue of PHY_NUM entries, each ID_W bits. Pointers head, tail and commit_head are ID_W+1 bits with a wrap bit. free_cnt = tail - head.
- Reset: entry k = ARCH_NUM+k for k < PHY_NUM-ARCH_NUM; head = commit_head = 0; tail = PHY_NUM-ARCH_NUM; all ckpt_vld = 0; ckpt_err = 0; free_cnt = PHY_NUM-ARCH_NUM.
- Allocation (combinational): req[i] = rdy[i] & ~zero[i]. v_alloc_id[i] = q[head + popcount(req[i-1:0])] when req[i]; otherwise 0. The sequential update is head += popcount(req & vld). A non-prefix rdy, or rdy without vld, is a protocol error and is covered by an assertion.
- Release: each channel with v_release_en & (id != 0) writes to q[tail + popcount(earlier valid releases)]; tail advances by the count. IDs are compacted in channel order. Overflow (free_cnt + releases > PHY_NUM) is flagged by an assertion.
- Commit: commit_head += popcount(v_commit_en & v_commit_alloc).
- Head priority (next-state): cancel_edge_en > restore_en (valid tag) > normal allocation.
  - cancel: head <= commit_head_next. Same-cycle allocations are dropped. Commits and releases still apply. All ckpt_vld are cleared.
  - restore: head <= ckpt_ptr[restore_tag]. Same-cycle allocation is dropped. ckpt_vld of the restored slot and of all younger slots is cleared; younger means slots taken after it, tracked by a per-slot age matrix. Releases and commits still apply.
  - restore on an invalid slot: head follows normal allocation and ckpt_err = 1 next cycle.
- Checkpoint: on ckpt_en, ckpt_ptr[tag] <= head after this cycle's allocations, and ckpt_vld[tag] <= 1. It is ignored if the same cycle has a cancel or a valid restore. Taking a checkpoint into an already-valid slot overwrites it.
- ckpt_free_en clears ckpt_vld[tag]. If ckpt_free and ckpt_en target the same tag, ckpt_en wins.
- Outputs v_alloc_vld and v_alloc_id reflect the registered state plus current rdy/zero: zero-cycle offer, one-cycle update. free_cnt is updated on the cycle after each event.
- Asserting rst_n low mid-operation restores reset state immediately, regardless of pending checkpoints.

Test Plan:
- Reset, then rdy=4'b1111, zero=0 -> ids 32,33,34,35; next cycle free_cnt=28, vld=4'b1111.
- rdy=4'b0111, zero=4'b0010 -> lane0=32, lane1=0, lane2=33; head advances by 2; free_cnt=30.
- Allocate until free_cnt=2 -> vld=4'b0011. Then release ids 5 and 9 on channels 0 and 2 -> free_cnt=4; subsequent allocations return 5 then 9 at the tail.
- Checkpoint tag1 after allocating 32..35, allocate 36..39, then restore tag1 -> next offered id 36; free_cnt=28; ckpt_vld[1]=0. A second restore of tag1 -> ckpt_err pulse, head unchanged.
- Commit 2 allocating instructions, allocate 4 more, assert cancel_edge_en together with rdy=4'b1111 -> head=commit_head=2; offered id 34; all ckpt_vld=0.
- Assert rst_n low mid-burst with 3 checkpoints valid -> free_cnt=32, ids restart at 32, ckpt_err=0.

Source files
------------

// File: rtl/toy_phy_freelist_ckpt.sv
// toy_phy_freelist_ckpt: rename-stage physical register free list with committed-head cancel and branch checkpoints
module toy_phy_freelist_ckpt #(
    parameter int MODE       = 0,
    parameter int PHY_NUM    = 64,
    parameter int ARCH_NUM   = 32,
    parameter int DECODE_NUM = 4,
    parameter int COMMIT_NUM = 4,
    parameter int CKPT_NUM   = 4,
    parameter int ID_W       = $clog2(PHY_NUM),
    parameter int CK_W       = $clog2(CKPT_NUM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [DECODE_NUM-1:0]      v_alloc_vld,
    input  logic [DECODE_NUM-1:0]      v_alloc_rdy,
    input  logic [DECODE_NUM-1:0]      v_alloc_zero,
    output logic [DECODE_NUM*ID_W-1:0] v_alloc_id,
    input  logic [COMMIT_NUM-1:0]      v_commit_en,
    input  logic [COMMIT_NUM-1:0]      v_commit_alloc,
    input  logic [COMMIT_NUM-1:0]      v_release_en,
    input  logic [COMMIT_NUM*ID_W-1:0] v_release_id,
    input  logic                       cancel_edge_en,
    input  logic                       ckpt_en,
    input  logic [CK_W-1:0]            ckpt_tag,
    input  logic                       restore_en,
    input  logic [CK_W-1:0]            restore_tag,
    input  logic                       ckpt_free_en,
    input  logic [CK_W-1:0]            ckpt_free_tag,
    output logic [ID_W:0]              free_cnt,
    output logic                       ckpt_err
);
    logic [ID_W-1:0]       r_q [PHY_NUM];
    logic [ID_W:0]         r_head, r_tail, r_chead;
    logic [ID_W:0]         r_ckpt_ptr [CKPT_NUM];
    logic [CKPT_NUM-1:0]   r_ckpt_vld;
    logic [CKPT_NUM-1:0]   r_age [CKPT_NUM];
    logic                  r_ckpt_err;
    logic [DECODE_NUM-1:0] w_req, w_rdy_p1;
    logic [ID_W:0]         w_off, w_alloc_cnt, w_rel_cnt, w_commit_cnt;
    logic [ID_W:0]         w_head_alloc, w_chead_next, w_head_next;
    logic [ID_W-1:0]       w_rel_pos [COMMIT_NUM];
    logic [COMMIT_NUM-1:0] w_rel;
    logic                  w_restore_ok, w_take;
    logic [CKPT_NUM-1:0]   w_vld_next, w_tag_oh;

    assign w_req        = v_alloc_rdy & ~v_alloc_zero;
    assign free_cnt     = r_tail - r_head;
    assign ckpt_err     = r_ckpt_err;
    assign w_chead_next = r_chead + w_commit_cnt;
    assign w_head_alloc = r_head + w_alloc_cnt;
    assign w_restore_ok = restore_en && r_ckpt_vld[restore_tag] && !cancel_edge_en;
    assign w_take       = ckpt_en && !cancel_edge_en && !w_restore_ok;
    assign w_tag_oh     = CKPT_NUM'(1) << ckpt_tag;
    assign w_head_next  = cancel_edge_en ? w_chead_next : w_restore_ok ? r_ckpt_ptr[restore_tag] : w_head_alloc;

    // Lane offsets count requesting lanes below; the head only moves past lanes that were offered an ID.
    always_comb begin
        w_off       = '0;
        w_alloc_cnt = '0;
        v_alloc_vld = '0;
        v_alloc_id  = '0;
        for (int i = 0; i < DECODE_NUM; i++) begin
            v_alloc_vld[i] = free_cnt > (ID_W+1)'(i);
            v_alloc_id[i*ID_W +: ID_W] = w_req[i] ? r_q[ID_W'(r_head + w_off)] : '0;
            w_alloc_cnt = w_alloc_cnt + (ID_W+1)'(w_req[i] & v_alloc_vld[i]);
            w_off = w_off + (ID_W+1)'(w_req[i]);
        end
    end

    always_comb begin
        w_rel        = '0;
        w_rel_cnt    = '0;
        w_commit_cnt = '0;
        for (int c = 0; c < COMMIT_NUM; c++) begin
            w_rel[c]     = v_release_en[c] && v_release_id[c*ID_W +: ID_W] != '0;
            w_rel_pos[c] = ID_W'(r_tail + w_rel_cnt);
            w_rel_cnt    = w_rel_cnt + (ID_W+1)'(w_rel[c]);
            w_commit_cnt = w_commit_cnt + (ID_W+1)'(v_commit_en[c] & v_commit_alloc[c]);
        end
    end

    // A restore kills its own slot plus every slot recorded as taken after it.
    always_comb begin
        w_vld_next = r_ckpt_vld;
        if (ckpt_free_en) w_vld_next[ckpt_free_tag] = 1'b0;
        if (w_take) w_vld_next[ckpt_tag] = 1'b1;
        if (w_restore_ok) w_vld_next = w_vld_next & ~r_age[restore_tag] & ~(CKPT_NUM'(1) << restore_tag);
        if (cancel_edge_en) w_vld_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PHY_NUM; k++) r_q[k] <= (k < PHY_NUM - ARCH_NUM) ? ID_W'(ARCH_NUM + k) : '0;
            for (int s = 0; s < CKPT_NUM; s++) begin
                r_ckpt_ptr[s] <= '0;
                r_age[s]      <= '0;
            end
            r_head     <= '0;
            r_chead    <= '0;
            r_tail     <= (ID_W+1)'(PHY_NUM - ARCH_NUM);
            r_ckpt_vld <= '0;
            r_ckpt_err <= 1'b0;
        end else begin
            for (int c = 0; c < COMMIT_NUM; c++)
                if (w_rel[c]) r_q[w_rel_pos[c]] <= v_release_id[c*ID_W +: ID_W];
            r_head     <= w_head_next;
            r_tail     <= r_tail + w_rel_cnt;
            r_chead    <= w_chead_next;
            r_ckpt_vld <= w_vld_next;
            r_ckpt_err <= restore_en && !cancel_edge_en && !r_ckpt_vld[restore_tag];
            if (w_take) begin
                r_ckpt_ptr[ckpt_tag] <= w_head_alloc;
                for (int s = 0; s < CKPT_NUM; s++)
                    r_age[s] <= (CK_W'(s) == ckpt_tag) ? '0 : (r_age[s] | w_tag_oh);
            end
        end
    end

    assign w_rdy_p1 = v_alloc_rdy + DECODE_NUM'(1);

    a_param:   assert property (@(posedge clk) (MODE == 0 || MODE == 1) && (PHY_NUM & (PHY_NUM - 1)) == 0 && (CKPT_NUM & (CKPT_NUM - 1)) == 0);
    a_prefix:  assert property (@(posedge clk) disable iff (!rst_n) (v_alloc_rdy & w_rdy_p1) == '0);
    a_rdy_vld: assert property (@(posedge clk) disable iff (!rst_n) (v_alloc_rdy & ~v_alloc_vld) == '0);
    a_ovf:     assert property (@(posedge clk) disable iff (!rst_n) {1'b0, free_cnt} + {1'b0, w_rel_cnt} <= (ID_W+2)'(PHY_NUM));
endmodule

// File: tb/tb_toy_phy_freelist_ckpt.sv
// tb_toy_phy_freelist_ckpt: scoreboard bench with an unbounded-log reference model of the free list
`timescale 1ns/1ps
module tb_toy_phy_freelist_ckpt;
    localparam int PHY = 64, ARCH = 32, DN = 4, CN = 4, CK = 4, IDW = 6, CKW = 2;

    typedef struct packed {
        logic [DN-1:0]     rdy, zero;
        logic [CN-1:0]     cen, calloc, ren;
        logic [CN*IDW-1:0] rid;
        logic              cancel, cken;
        logic [CKW-1:0]    cktag;
        logic              rsen;
        logic [CKW-1:0]    rstag;
        logic              fen;
        logic [CKW-1:0]    ftag;
    } stim_t;

    typedef struct packed {
        logic [DN-1:0]     vld;
        logic [DN*IDW-1:0] id;
        logic [IDW:0]      free;
        logic              err;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [DN-1:0] vld, rdy, zero;
    logic [DN*IDW-1:0] id;
    logic [CN-1:0] cen, calloc, ren;
    logic [CN*IDW-1:0] rid;
    logic cancel, cken, rsen, fen, err;
    logic [CKW-1:0] cktag, rstag, ftag;
    logic [IDW:0] free;

    exp_t exp_q[$];
    exp_t me;
    int n_cmp = 0, n_mis = 0;

    int log_q[$];
    int m_head, m_chead, m_seq_cnt;
    int m_ptr[CK], m_seq[CK];
    bit m_vld[CK];
    bit m_err;

    always #5 clk = ~clk;

    toy_phy_freelist_ckpt #(.MODE(0), .PHY_NUM(PHY), .ARCH_NUM(ARCH), .DECODE_NUM(DN), .COMMIT_NUM(CN), .CKPT_NUM(CK)) dut (
        .clk(clk), .rst_n(rst_n),
        .v_alloc_vld(vld), .v_alloc_rdy(rdy), .v_alloc_zero(zero), .v_alloc_id(id),
        .v_commit_en(cen), .v_commit_alloc(calloc), .v_release_en(ren), .v_release_id(rid),
        .cancel_edge_en(cancel), .ckpt_en(cken), .ckpt_tag(cktag),
        .restore_en(rsen), .restore_tag(rstag), .ckpt_free_en(fen), .ckpt_free_tag(ftag),
        .free_cnt(free), .ckpt_err(err)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("alloc_vld", 32'(vld), 32'(me.vld));
            chk("alloc_id", 32'(id), 32'(me.id));
            chk("free_cnt", 32'(free), 32'(me.free));
            chk("ckpt_err", 32'(err), 32'(me.err));
        end
    end

    function automatic void model_reset();
        log_q.delete();
        for (int k = 0; k < PHY - ARCH; k++) log_q.push_back(ARCH + k);
        m_head = 0;
        m_chead = 0;
        m_seq_cnt = 0;
        m_err = 0;
        for (int j = 0; j < CK; j++) begin
            m_vld[j] = 0;
            m_ptr[j] = 0;
            m_seq[j] = 0;
        end
    endfunction

    function automatic void apply(input stim_t s);
        rdy = s.rdy; zero = s.zero; cen = s.cen; calloc = s.calloc; ren = s.ren; rid = s.rid;
        cancel = s.cancel; cken = s.cken; cktag = s.cktag; rsen = s.rsen; rstag = s.rstag;
        fen = s.fen; ftag = s.ftag;
    endfunction

    // One cycle: predict outputs from the model, queue them, then advance the model.
    task automatic drive(input stim_t s);
        exp_t e;
        int off, chn, s0;
        bit rok, rvld;
        @(posedge clk);
        #1;
        apply(s);
        e = '0;
        e.free = 7'(log_q.size() - m_head);
        e.err = m_err;
        off = 0;
        for (int i = 0; i < DN; i++) begin
            e.vld[i] = (log_q.size() - m_head) > i;
            if (s.rdy[i] && !s.zero[i]) begin
                e.id[i*IDW +: IDW] = 6'(log_q[m_head + off]);
                off++;
            end
        end
        exp_q.push_back(e);
        rvld = m_vld[s.rstag];
        chn = m_chead + $countones(s.cen & s.calloc);
        rok = s.rsen && rvld && !s.cancel;
        if (s.fen) m_vld[s.ftag] = 0;
        if (s.cken && !s.cancel && !rok) begin
            m_seq_cnt++;
            m_ptr[s.cktag] = m_head + off;
            m_vld[s.cktag] = 1;
            m_seq[s.cktag] = m_seq_cnt;
        end
        if (rok) begin
            s0 = m_seq[s.rstag];
            for (int j = 0; j < CK; j++) if (m_seq[j] >= s0) m_vld[j] = 0;
        end
        if (s.cancel) for (int j = 0; j < CK; j++) m_vld[j] = 0;
        m_err = s.rsen && !s.cancel && !rvld;
        m_head = s.cancel ? chn : rok ? m_ptr[s.rstag] : m_head + off;
        m_chead = chn;
        for (int c = 0; c < CN; c++)
            if (s.ren[c] && s.rid[c*IDW +: IDW] != 0) log_q.push_back(int'(s.rid[c*IDW +: IDW]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        apply('0);
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic stim_t st(input logic [DN-1:0] r, input logic [DN-1:0] z);
        stim_t s = '0;
        s.rdy = r;
        s.zero = z;
        return s;
    endfunction

    // Legal random cycle: prefix rdy within vld, commits never pass any live pointer, no list overflow.
    function automatic stim_t gen(input bit starve);
        stim_t s = '0;
        int fr, n, lim, room, cnt;
        fr = log_q.size() - m_head;
        n = $urandom_range(fr < DN ? fr : DN, 0);
        s.rdy = 4'((1 << n) - 1);
        s.zero = 4'($urandom & $urandom & $urandom);
        s.cancel = $urandom_range(39, 0) == 0;
        s.rsen = !s.cancel && $urandom_range(7, 0) == 0;
        s.rstag = 2'($urandom);
        s.cken = $urandom_range(3, 0) == 0;
        s.cktag = 2'($urandom);
        s.fen = $urandom_range(7, 0) == 0;
        s.ftag = 2'($urandom);
        lim = m_head - m_chead;
        for (int j = 0; j < CK; j++) if (m_vld[j] && m_ptr[j] - m_chead < lim) lim = m_ptr[j] - m_chead;
        s.cen = 4'($urandom);
        s.calloc = 4'($urandom);
        cnt = 0;
        for (int c = 0; c < CN; c++)
            if (s.cen[c] && s.calloc[c]) begin
                if (cnt < lim) cnt++;
                else s.calloc[c] = 1'b0;
            end
        room = PHY - (log_q.size() - m_chead);
        s.ren = starve ? 4'b0 : 4'($urandom);
        s.rid = 24'($urandom);
        cnt = 0;
        for (int c = 0; c < CN; c++)
            if (s.ren[c] && s.rid[c*IDW +: IDW] != 0) begin
                if (cnt < room) cnt++;
                else s.ren[c] = 1'b0;
            end
        return s;
    endfunction

    initial begin
        stim_t s;
        apply('0);
        model_reset();
        do_reset();
        drive(st(4'b1111, 4'b0000));
        drive(st(4'b0000, 4'b0000));
        do_reset();
        drive(st(4'b0111, 4'b0010));
        drive(st(4'b0000, 4'b0000));
        do_reset();
        repeat (7) drive(st(4'b1111, 4'b0000));
        drive(st(4'b0011, 4'b0000));
        s = st(4'b0000, 4'b0000);
        s.ren = 4'b0101;
        s.rid = {6'd0, 6'd9, 6'd0, 6'd5};
        drive(s);
        drive(st(4'b0011, 4'b0000));
        drive(st(4'b0011, 4'b0000));
        drive(st(4'b0000, 4'b0000));
        do_reset();
        s = st(4'b1111, 4'b0000);
        s.cken = 1'b1;
        s.cktag = 2'd1;
        drive(s);
        drive(st(4'b1111, 4'b0000));
        s = st(4'b1111, 4'b0000);
        s.rsen = 1'b1;
        s.rstag = 2'd1;
        drive(s);
        drive(st(4'b0001, 4'b0000));
        s = st(4'b0000, 4'b0000);
        s.rsen = 1'b1;
        s.rstag = 2'd1;
        drive(s);
        drive(st(4'b0000, 4'b0000));
        do_reset();
        s = st(4'b1111, 4'b0000);
        s.cken = 1'b1;
        s.cktag = 2'd2;
        drive(s);
        s = st(4'b0000, 4'b0000);
        s.cen = 4'b0011;
        s.calloc = 4'b0011;
        drive(s);
        drive(st(4'b1111, 4'b0000));
        s = st(4'b1111, 4'b0000);
        s.cancel = 1'b1;
        drive(s);
        s = st(4'b0001, 4'b0000);
        s.rsen = 1'b1;
        s.rstag = 2'd2;
        drive(s);
        drive(st(4'b0000, 4'b0000));
        do_reset();
        for (int t = 0; t < 3; t++) begin
            s = st(4'b1111, 4'b0000);
            s.cken = 1'b1;
            s.cktag = 2'(t);
            drive(s);
        end
        drive(st(4'b1111, 4'b0000));
        do_reset();
        s = st(4'b1111, 4'b0000);
        s.rsen = 1'b1;
        s.rstag = 2'd0;
        drive(s);
        drive(st(4'b0000, 4'b0000));
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 900 == 899) do_reset();
            drive(gen(((cyc / 150) % 3) == 1));
        end
        @(negedge clk);
        #2;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
